// File: rtl/sram_pattern_initiator_if.sv
// Word-wide SRAM port between a bus master and a registered-read memory responder.
// The master drives address, write strobe and write data; read data returns one cycle later.
interface sram_pattern_initiator_if;
  logic [31:0] addr_o;
  logic        write_en_o;
  logic [31:0] data_o;
  logic [31:0] data_i;

  modport master (output addr_o, output write_en_o, output data_o, input data_i);
  modport slave  (input addr_o, input write_en_o, input data_o, output data_i);
endinterface

// File: rtl/sram_pattern_initiator.sv
// SRAM self-test initiator: fills a word region with SEED ^ {~i, i}, reads it back,
// and reports pass/fail, a saturating mismatch count and the first failing byte address.
module sram_pattern_initiator #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [31:0] SEED      = 32'h0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic [15:0]                       err_count_o,
  output logic [31:0]                       first_err_addr_o,
  sram_pattern_initiator_if.master          mem
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [31:0] first_q, first_d;
  logic        cmp_valid_q, cmp_valid_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] exp_addr_q, exp_addr_d;

  function automatic logic [31:0] pattern(input logic [15:0] i);
    return SEED ^ {~i, i};
  endfunction

  function automatic logic [31:0] word_addr(input logic [15:0] i);
    return BASE_ADDR + {14'd0, i, 2'b00};
  endfunction

  logic        last_word;
  logic [15:0] idx_inc;
  logic        mismatch;

  assign last_word = (idx_q == LAST_IDX);
  assign idx_inc   = idx_q + 16'd1;
  assign mismatch  = cmp_valid_q && (mem.data_i != exp_q);

  // Every output is produced from the next state, so the bus and status pins are all flops.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = 32'h0;
    we_d        = 1'b0;
    wdata_d     = 32'h0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    first_d     = first_q;
    cmp_valid_d = 1'b0;
    exp_d       = exp_q;
    exp_addr_d  = exp_addr_q;

    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'h0)    first_d = exp_addr_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WRITE;
          idx_d   = 16'd0;
          addr_d  = word_addr(16'd0);
          we_d    = 1'b1;
          wdata_d = pattern(16'd0);
          busy_d  = 1'b1;
          err_d   = 16'h0;
          first_d = 32'h0;
          pass_d  = 1'b0;
        end
      end
      WRITE: begin
        busy_d = 1'b1;
        if (last_word) begin
          state_d = READ;
          idx_d   = 16'd0;
          addr_d  = word_addr(16'd0);
        end else begin
          idx_d   = idx_inc;
          addr_d  = word_addr(idx_inc);
          we_d    = 1'b1;
          wdata_d = pattern(idx_inc);
        end
      end
      READ: begin
        // Read data arrives a cycle late, so the expected word and its address ride one stage behind.
        busy_d      = 1'b1;
        cmp_valid_d = 1'b1;
        exp_d       = pattern(idx_q);
        exp_addr_d  = addr_q;
        if (last_word) begin
          state_d = DRAIN;
        end else begin
          idx_d  = idx_inc;
          addr_d = word_addr(idx_inc);
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == 16'h0);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 16'd0;
      addr_q      <= 32'h0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 16'h0;
      first_q     <= 32'h0;
      cmp_valid_q <= 1'b0;
      exp_q       <= 32'h0;
      exp_addr_q  <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_q     <= first_d;
      cmp_valid_q <= cmp_valid_d;
      exp_q       <= exp_d;
      exp_addr_q  <= exp_addr_d;
    end
  end

  assign mem.addr_o       = addr_q;
  assign mem.write_en_o   = we_q;
  assign mem.data_o       = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_sram_pattern_initiator.sv
// Directed bench: three initiator configurations, two backed by a registered-read memory model.
`timescale 1ns/1ps
module tb_sram_pattern_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = 3'b000;
  logic [2:0]  busy, done, pass;
  logic [15:0] err   [3];
  logic [31:0] first [3];
  logic        flip = 1'b0;
  int          sel = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  sram_pattern_initiator_if if0 ();
  sram_pattern_initiator_if if1 ();
  sram_pattern_initiator_if if2 ();

  sram_pattern_initiator dut0 (
    .clk(clk), .rst(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .pass_o(pass[0]), .err_count_o(err[0]), .first_err_addr_o(first[0]), .mem(if0.master));

  sram_pattern_initiator #(.BASE_ADDR(32'h100), .NUM_WORDS(16), .SEED(32'hA5A5A5A5)) dut1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .pass_o(pass[1]), .err_count_o(err[1]), .first_err_addr_o(first[1]), .mem(if1.master));

  sram_pattern_initiator #(.NUM_WORDS(1)) dut2 (
    .clk(clk), .rst(rst), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
    .pass_o(pass[2]), .err_count_o(err[2]), .first_err_addr_o(first[2]), .mem(if2.master));

  logic [31:0] mem0 [0:4095];
  logic [31:0] mem2 [0:4095];

  always @(posedge clk) begin
    if (if0.write_en_o) mem0[if0.addr_o[13:2]] <= if0.data_o;
    if0.data_i <= mem0[if0.addr_o[13:2]] ^
                  {31'd0, flip && !if0.write_en_o && (if0.addr_o == 32'h14)};
    if (if2.write_en_o) mem2[if2.addr_o[13:2]] <= if2.data_o;
    if2.data_i <= mem2[if2.addr_o[13:2]];
  end

  assign if1.data_i = 32'h0;

  logic [31:0] obs_addr, obs_data;
  logic        obs_we;
  always_comb begin
    obs_addr = if0.addr_o;
    obs_data = if0.data_o;
    obs_we   = if0.write_en_o;
    case (sel)
      1: begin obs_addr = if1.addr_o; obs_data = if1.data_o; obs_we = if1.write_en_o; end
      2: begin obs_addr = if2.addr_o; obs_data = if2.data_o; obs_we = if2.write_en_o; end
      default: ;
    endcase
  end

  function automatic logic [31:0] pat(input logic [31:0] seed, input int i);
    logic [15:0] w;
    w = 16'(i);
    return seed ^ {~w, w};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      tests++;
      if ({obs_addr, obs_data, obs_we, busy[s], done[s], pass[s], err[s], first[s]} !== '0) begin
        fails++;
        $display("FAIL reset dut%0d: addr=%h data=%h we=%b busy=%b done=%b pass=%b err=%h first=%h, required all 0",
                 s, obs_addr, obs_data, obs_we, busy[s], done[s], pass[s], err[s], first[s]);
      end
    end
    rst = 1'b0;
  endtask

  // Pulses start on dut s, then checks the bus and status pins every cycle through two idle cycles after done.
  task automatic run_check(input string name, input int s, input int n, input logic [31:0] base,
                           input logic [31:0] seed, input int repulse, input logic exp_pass,
                           input logic [15:0] exp_err, input logic [31:0] exp_first);
    logic [31:0] e_addr, e_data;
    logic        e_we, e_busy, e_done;
    sel = s;
    @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    for (int c = 1; c <= 2*n + 5; c++) begin
      e_we   = (c >= 1) && (c <= n);
      e_busy = (c <= 2*n + 1);
      e_done = (c == 2*n + 2);
      e_data = e_we ? pat(seed, c - 1) : 32'h0;
      if (c <= n)            e_addr = base + 32'(4*(c - 1));
      else if (c <= 2*n)     e_addr = base + 32'(4*(c - n - 1));
      else                   e_addr = 32'h0;
      tests++;
      if ({obs_addr, obs_data, obs_we, busy[s], done[s]} !== {e_addr, e_data, e_we, e_busy, e_done}) begin
        fails++;
        $display("FAIL %s bus cycle k+%0d: addr=%h data=%h we=%b busy=%b done=%b, required addr=%h data=%h we=%b busy=%b done=%b",
                 name, c, obs_addr, obs_data, obs_we, busy[s], done[s], e_addr, e_data, e_we, e_busy, e_done);
      end
      if (c == 1) begin
        tests++;
        if ({pass[s], err[s], first[s]} !== {1'b0, 16'h0, 32'h0}) begin
          fails++;
          $display("FAIL %s results cleared at k+1: pass=%b err=%h first=%h, required 0/0000/00000000",
                   name, pass[s], err[s], first[s]);
        end
      end
      if (c >= 2*n + 2) begin
        tests++;
        if ({pass[s], err[s], first[s]} !== {exp_pass, exp_err, exp_first}) begin
          fails++;
          $display("FAIL %s results at k+%0d: pass=%b err=%h first=%h, required pass=%b err=%h first=%h",
                   name, c, pass[s], err[s], first[s], exp_pass, exp_err, exp_first);
        end
      end
      start[s] = (c == repulse);
      @(posedge clk);
      #1;
    end
    start[s] = 1'b0;
  endtask

  task automatic test_basic();
    run_check("basic", 0, 16, 32'h0, 32'h0, 0, 1'b1, 16'h0, 32'h0);
  endtask

  task automatic test_error_inject();
    flip = 1'b1;
    run_check("flip_word5", 0, 16, 32'h0, 32'h0, 0, 1'b0, 16'h1, 32'h14);
    flip = 1'b0;
  endtask

  task automatic test_start_ignored();
    run_check("start_in_read", 0, 16, 32'h0, 32'h0, 20, 1'b1, 16'h0, 32'h0);
  endtask

  task automatic test_seed_base();
    run_check("seed_base_zero_data", 1, 16, 32'h100, 32'hA5A5A5A5, 0, 1'b0, 16'd16, 32'h100);
  endtask

  task automatic test_single_word();
    run_check("single_word", 2, 1, 32'h0, 32'h0, 0, 1'b1, 16'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tests++;
    if ({obs_we, obs_addr, obs_data} !== {1'b1, 32'h8, 32'hFFFD0002}) begin
      fails++;
      $display("FAIL reset_mid third write: we=%b addr=%h data=%h, required 1/00000008/fffd0002",
               obs_we, obs_addr, obs_data);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({obs_addr, obs_data, obs_we, busy[0], done[0], pass[0], err[0], first[0]} !== '0) begin
      fails++;
      $display("FAIL reset_mid after edge: addr=%h data=%h we=%b busy=%b done=%b pass=%b err=%h first=%h, required all 0",
               obs_addr, obs_data, obs_we, busy[0], done[0], pass[0], err[0], first[0]);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({done[0], busy[0], obs_we} !== 3'b000) begin
        fails++;
        $display("FAIL reset_mid aborted idle %0d: done=%b busy=%b we=%b, required 0/0/0",
                 c, done[0], busy[0], obs_we);
      end
    end
    run_check("after_reset", 0, 16, 32'h0, 32'h0, 0, 1'b1, 16'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error_inject();
    test_start_ignored();
    test_seed_base();
    test_single_word();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_pattern_initiator.md
# sram_pattern_initiator

Built-in self-test initiator for the word-wide SRAM port (the `addr_o` / `write_en_o` / `data_o` / `data_i` interface served by `mem16k`). On a start pulse it fills a contiguous word region with a deterministic pattern, reads every word back, and compares each one against the expected value. It then reports pass/fail, a saturating error count and the first failing address. It sits in the testbench or an SoC debug path in place of `mod_main` as the bus master, so the memory responder can be exercised without a compiled Karuta design.

## Interface
- `BASE_ADDR`, 32'h0: byte address of word 0; must be word-aligned (bits [1:0] = 0).
- `NUM_WORDS`, 16: words tested, 1..65535.
- `SEED`, 32'h0: XOR mask applied to the pattern.

- `clk`  in  1: clock; all logic samples on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start_i`  in  1: begin test; sampled only in IDLE.
- `busy_o`  out  1: test in progress.
- `done_o`  out  1: one-cycle completion pulse.
- `pass_o`  out  1: result of the last completed test; held until the next start.
- `err_count_o`  out  16: mismatches in the last test; saturates at 16'hFFFF.
- `first_err_addr_o`  out  32: byte address of the first mismatch; 0 if none.
- `addr_o`  out  32: SRAM byte address; the memory indexes it with `addr_o[31:2]`.
- `write_en_o`  out  1: SRAM write strobe.
- `data_o`  out  32: SRAM write data.
- `data_i`  in  32: SRAM read data, registered by the memory; one-cycle latency.

## Operation
- Pattern for word index i (16-bit): `pattern(i) = SEED ^ {~i, i}`.
  - With SEED = 0: i = 0 gives 32'hFFFF0000; i = 5 gives 32'hFFFA0005.
- Address for word i is `BASE_ADDR + 4*i`, computed modulo 2^32 (wraps silently).
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - All SRAM outputs are 0.
  - `start_i` = 1 → WRITE; i = 0; `err_count_o` and `first_err_addr_o` are cleared and `pass_o` goes to 0.
- WRITE:
  - Each cycle: `write_en_o` = 1, address of word i, `data_o` = pattern(i).
  - After i = NUM_WORDS-1 → READ with i = 0.
- READ:
  - Each cycle: `write_en_o` = 0, address of word i, `data_o` = 0.
  - The expected value pattern(i) and the valid flag are delayed one cycle.
  - The comparison for word i uses `data_i` in the following cycle.
  - After i = NUM_WORDS-1 → DRAIN.
- DRAIN: no access (`write_en_o` = 0, `addr_o` = 0); compares the last word; → DONE.
- DONE: `done_o` = 1; `pass_o` = (err_count == 0); → IDLE.
- On each mismatch:
  - `err_count_o` increments unless it is already 16'hFFFF.
  - If this is the first mismatch of the test, its byte address is latched into `first_err_addr_o`.
- `start_i` is ignored in every state except IDLE.
- The word counter is 16 bits wide; the end-of-phase compare uses NUM_WORDS-1, so NUM_WORDS = 1 is legal.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state returns to IDLE.
- Reset asserted mid-test:
  - `write_en_o` is 0 in the cycle after the reset edge.
  - The test is aborted and no `done_o` is produced.
  - Results are cleared.
- For `start_i` sampled at edge k, with N = NUM_WORDS:
  - Writes occur in cycles k+1 .. k+N.
  - Reads are issued in cycles k+N+1 .. k+2N.
  - DRAIN is cycle k+2N+1.
  - `done_o` is high in cycle k+2N+2 only.
  - `busy_o` is high in cycles k+1 .. k+2N+1.
- Total test length: 2N+2 cycles from start to done.
- The last write (cycle k+N) is followed immediately by the first read (cycle k+N+1). The memory must return the newly written data with no bubble.
- `pass_o`, `err_count_o` and `first_err_addr_o` are stable from the `done_o` cycle until the next accepted start.
- Back-to-back runs: `start_i` held high through DONE is accepted in the following IDLE cycle, so the next run starts two cycles after `done_o`.

## Test plan
- Defaults with a `mem16k` responder, start pulse → 16 writes (addresses 0x00..0x3C, first data 32'hFFFF0000), 16 reads, `done_o` at k+34, `pass_o` = 1, `err_count_o` = 0.
- Bench flips bit 0 of `data_i` during the read-back of word 5 → `err_count_o` = 1, `first_err_addr_o` = 32'h14, `pass_o` = 0.
- BASE_ADDR = 32'h100, SEED = 32'hA5A5A5A5, bench returns `data_i` = 0 for every read → `err_count_o` = 16, `first_err_addr_o` = 32'h100.
- NUM_WORDS = 1 → one write of 32'hFFFF0000 to address 0, one read, `done_o` at k+4, `pass_o` = 1.
- `start_i` pulsed again during READ → ignored; a single `done_o`, at the original cycle.
- `rst` asserted in the 3rd WRITE cycle → next cycle all outputs are 0 and the block is in IDLE; a fresh start then completes normally with `pass_o` = 1.
